// File: rtl/cpu_dsram_bridge.sv
// CPU data-port to split-handshake SRAM bridge: captures one CPU access, issues it
// downstream with addr_ok/data_ok handshaking, and stalls the CPU until completion.
module cpu_dsram_bridge #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  cpu_en,
   input  logic [3:0]            cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [31:0]           cpu_wdata,
   output logic [31:0]           cpu_rdata,
   output logic                  cpu_stall,
   output logic                  req,
   output logic                  wr,
   output logic [1:0]            size,
   output logic [3:0]            wstrb,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [31:0]           wdata,
   input  logic                  addr_ok,
   input  logic                  data_ok,
   input  logic [31:0]           rdata,
   output logic [31:0]           stall_cnt
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

   state_t                state, state_nxt;
   logic [3:0]            we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic                  rd_done;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Handshakes outside REQ/WAIT fall through untouched, so stray oks are ignored.
   always_comb begin
      state_nxt = state;
      rd_done   = 1'b0;
      case (state)
         ST_IDLE: if (cpu_en) state_nxt = ST_REQ;
         ST_REQ: begin
            if (addr_ok) begin
               if (data_ok) begin
                  state_nxt = ST_DONE;
                  rd_done   = ~|we_q;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (data_ok) begin
               state_nxt = ST_DONE;
               rd_done   = ~|we_q;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         we_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (state == ST_IDLE && cpu_en) begin
         we_q    <= cpu_we;
         addr_q  <= cpu_addr;
         wdata_q <= cpu_wdata;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      cpu_rdata <= '0;
      else if (rd_done) cpu_rdata <= rdata;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                         stall_cnt <= '0;
      else if (cpu_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
   end

   // Stall is gated by resetn so a held cpu_en cannot stall the CPU during reset.
   always_comb begin
      cpu_stall = resetn & ((state == ST_IDLE && cpu_en) || state == ST_REQ || state == ST_WAIT);
   end

   always_comb begin
      req   = 1'b0;
      wr    = 1'b0;
      size  = 2'd0;
      wstrb = '0;
      addr  = '0;
      wdata = '0;
      if (state == ST_REQ) begin
         req   = 1'b1;
         wr    = |we_q;
         wstrb = we_q;
         addr  = addr_q;
         wdata = wdata_q;
         case (we_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
            4'b0011, 4'b1100:                   size = 2'd1;
            default:                            size = 2'd2;
         endcase
      end
   end

endmodule
